// File: rtl/rtc_digit_overlay.sv
// rtc_digit_overlay: draws NUM_FIELDS two-digit BCD fields over a VGA stream using an
// external synchronous 8x16 font ROM. It snapshots the value once per frame and blinks the edited field.

module rtc_digit_cell #(
  parameter int XS         = 0,
  parameter int YS         = 0,
  parameter int W          = 32,
  parameter int H          = 64,
  parameter int SCALE_LOG2 = 2
) (
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic        hit,
  output logic [2:0]  col
);
  localparam logic [10:0] X_LO = 11'(XS);
  localparam logic [10:0] X_HI = 11'(XS + W);
  localparam logic [10:0] Y_LO = 11'(YS);
  localparam logic [10:0] Y_HI = 11'(YS + H);

  logic [10:0] dx;

  assign dx  = x - X_LO;
  assign hit = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
  assign col = 3'(dx >> SCALE_LOG2);
endmodule

module rtc_digit_overlay #(
  parameter int          NUM_FIELDS   = 3,
  parameter int          X0           = 192,
  parameter int          Y0           = 64,
  parameter int          SCALE_LOG2   = 2,
  parameter int          FIELD_GAP    = 64,
  parameter logic [11:0] FG_COLOR     = 12'h0FF,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              pix_x,
  input  logic [9:0]              pix_y,
  input  logic                    video_on,
  input  logic                    frame_tick,
  input  logic [8*NUM_FIELDS-1:0] time_bcd,
  input  logic                    edit_en,
  input  logic [1:0]              edit_field,
  output logic [7:0]              font_addr,
  input  logic [7:0]              font_data,
  output logic [11:0]             rgb_out,
  output logic                    text_hit
);
  localparam int W         = 8 << SCALE_LOG2;
  localparam int H         = 16 << SCALE_LOG2;
  localparam int PITCH     = 2 * W + FIELD_GAP;
  localparam int NUM_CELLS = 2 * NUM_FIELDS;
  localparam int CNT_W     = $clog2(BLINK_FRAMES + 1);

  logic [8*NUM_FIELDS-1:0] sh_bcd;
  logic                    sh_edit_en;
  logic [1:0]              sh_edit_field;
  logic [CNT_W-1:0]        blink_cnt;
  logic                    blink_phase;

  // Shadows only move on frame_tick so a whole frame renders one consistent value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_bcd        <= '0;
      sh_edit_en    <= 1'b0;
      sh_edit_field <= 2'd0;
      blink_cnt     <= '0;
      blink_phase   <= 1'b0;
    end else if (frame_tick) begin
      sh_bcd        <= time_bcd;
      sh_edit_en    <= edit_en;
      sh_edit_field <= edit_field;
      if (!edit_en) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (!sh_edit_en) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + 1'b1;
      end
    end
  end

  logic [10:0]                x11, y11, dy;
  logic [NUM_CELLS-1:0]       cell_hit;
  logic [NUM_CELLS-1:0][2:0]  cell_col;

  assign x11 = {1'b0, pix_x};
  assign y11 = {1'b0, pix_y};
  assign dy  = y11 - 11'(Y0);

  for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
    rtc_digit_cell #(
      .XS(X0 + (c / 2) * PITCH + (c % 2) * W), .YS(Y0),
      .W(W), .H(H), .SCALE_LOG2(SCALE_LOG2)
    ) u_cell (
      .x(x11), .y(y11), .hit(cell_hit[c]), .col(cell_col[c])
    );
  end

  logic       s0_hit, s0_blank;
  logic [2:0] s0_col;
  logic [3:0] s0_digit, s0_row;

  assign s0_row = 4'(dy >> SCALE_LOG2);

  always_comb begin
    s0_hit   = 1'b0;
    s0_col   = 3'd0;
    s0_digit = 4'd0;
    s0_blank = 1'b0;
    for (int c = 0; c < NUM_CELLS; c++) begin
      if (cell_hit[c]) begin
        s0_hit   = 1'b1;
        s0_col   = cell_col[c];
        s0_digit = sh_bcd[8*NUM_FIELDS-1 - 8*(c/2) - 4*(c%2) -: 4];
        // An out-of-range edit_field never matches any field index, so nothing blinks.
        s0_blank = (s0_digit > 4'd9) ||
                   (sh_edit_en && blink_phase && (2'(c / 2) == sh_edit_field));
      end
    end
  end

  logic [2:1]      hit_pipe, vid_pipe, blank_pipe;
  logic [2:1][2:0] col_pipe;
  logic            pix_on;

  always_ff @(posedge clk) begin
    if (reset) begin
      font_addr  <= 8'd0;
      hit_pipe   <= '0;
      vid_pipe   <= '0;
      blank_pipe <= '0;
      col_pipe   <= '0;
    end else begin
      if (s0_hit) font_addr <= {s0_digit, s0_row};
      hit_pipe   <= {hit_pipe[1], s0_hit};
      vid_pipe   <= {vid_pipe[1], video_on};
      blank_pipe <= {blank_pipe[1], s0_blank};
      col_pipe   <= {col_pipe[1], s0_col};
    end
  end

  // font_data lines up with stage 2; bit 7 is the leftmost glyph pixel.
  assign pix_on = font_data[3'd7 - col_pipe[2]] & hit_pipe[2] & ~blank_pipe[2] & vid_pipe[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_out  <= 12'd0;
      text_hit <= 1'b0;
    end else begin
      rgb_out  <= pix_on ? FG_COLOR : 12'd0;
      text_hit <= hit_pipe[2] & vid_pipe[2];
    end
  end
endmodule

// File: tb/tb_rtc_digit_overlay.sv
// Directed bench for rtc_digit_overlay; the font ROM is modelled with glyph row = ~address.
module tb_rtc_digit_overlay;
  localparam logic [11:0] FG = 12'h0FF;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pix_x, pix_y;
  logic        video_on, frame_tick;
  logic [23:0] time_bcd;
  logic        edit_en;
  logic [1:0]  edit_field;
  logic [7:0]  font_addr, font_data;
  logic [11:0] rgb_out;
  logic        text_hit;

  int checks = 0;
  int errors = 0;

  logic [11:0] line_rgb [0:639];
  logic        line_hit [0:639];

  rtc_digit_overlay #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
    .frame_tick(frame_tick), .time_bcd(time_bcd), .edit_en(edit_en), .edit_field(edit_field),
    .font_addr(font_addr), .font_data(font_data), .rgb_out(rgb_out), .text_hit(text_hit)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) font_data <= ~font_addr;

  task idle();
    pix_x = 10'd0; pix_y = 10'd0; video_on = 1'b0;
  endtask

  task tick();
    idle();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Present one pixel, return the stage-1 font_addr and the output 3 cycles later.
  task probe(input logic [9:0] x, input logic [9:0] y, input logic vid,
             output logic [7:0] addr, output logic [12:0] px);
    pix_x = x; pix_y = y; video_on = vid;
    @(negedge clk);
    addr = font_addr;
    idle();
    @(negedge clk);
    @(negedge clk);
    px = {text_hit, rgb_out};
  endtask

  task scan_line(input logic [9:0] y);
    for (int i = 0; i < 643; i++) begin
      if (i >= 3) begin
        line_rgb[i-3] = rgb_out;
        line_hit[i-3] = text_hit;
      end
      if (i < 640) begin
        pix_x = 10'(i); pix_y = y; video_on = 1'b1;
      end else begin
        idle();
      end
      @(negedge clk);
    end
  endtask

  // Expected {hit, rgb} for pixel x on a line with the given glyph row, default geometry.
  function automatic logic [12:0] exp_px(input int x, input logic [23:0] bcd, input int row);
    logic [3:0] d;
    logic [7:0] glyph;
    int xs;
    exp_px = 13'd0;
    for (int c = 0; c < 6; c++) begin
      xs = 192 + (c / 2) * 128 + (c % 2) * 32;
      if (x >= xs && x < xs + 32) begin
        d = bcd[23 - 4*c -: 4];
        glyph = ~{d, 4'(row)};
        exp_px = {1'b1, (glyph[7 - ((x - xs) >> 2)] && d <= 4'd9) ? FG : 12'd0};
      end
    end
  endfunction

  task test_reset();
    reset = 1'b1; frame_tick = 1'b1; time_bcd = 24'h123456; edit_en = 1'b0; edit_field = 2'd0;
    pix_x = 10'd192; pix_y = 10'd64; video_on = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({text_hit, rgb_out, font_addr} !== 21'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {text_hit, rgb_out, font_addr});
    end
    reset = 1'b0; frame_tick = 1'b0; idle();
    @(negedge clk);
    begin
      logic [7:0] a; logic [12:0] p;
      probe(10'd192, 10'd64, 1'b1, a, p);
      checks++;
      if (a !== 8'h00) begin errors++; $display("FAIL reset_shadow_addr got=%h exp=00", a); end
      checks++;
      if (p !== {1'b1, FG}) begin errors++; $display("FAIL reset_zero_digit got=%h exp=%h", p, {1'b1, FG}); end
    end
  endtask

  task test_basic_render();
    int bad, hits;
    time_bcd = 24'h123456;
    tick();
    scan_line(10'd64);
    bad = 0; hits = 0;
    for (int x = 0; x < 640; x++) begin
      if ({line_hit[x], line_rgb[x]} !== exp_px(x, 24'h123456, 0)) bad++;
      if (line_hit[x] === 1'b1) hits++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL basic_line bad_pixels=%0d exp=0", bad); end
    checks++;
    if (hits != 192) begin errors++; $display("FAIL basic_hit_count got=%0d exp=192", hits); end
    checks++;
    if ({line_hit[204], line_rgb[204]} !== {1'b1, 12'h000}) begin
      errors++; $display("FAIL basic_x204 got=%h exp=1000", {line_hit[204], line_rgb[204]});
    end
    checks++;
    if ({line_hit[256], line_hit[191], line_hit[448]} !== 3'b001) begin
      errors++; $display("FAIL basic_edges got=%b exp=001", {line_hit[256], line_hit[191], line_hit[448]});
    end
  endtask

  task test_latency_scaling();
    logic [7:0] a; logic [12:0] p;
    idle();
    repeat (4) @(negedge clk);
    pix_x = 10'd192; pix_y = 10'd64; video_on = 1'b1;
    @(negedge clk);
    checks++;
    if (font_addr !== 8'h10) begin errors++; $display("FAIL lat_addr_n1 got=%h exp=10", font_addr); end
    idle();
    @(negedge clk);
    checks++;
    if ({text_hit, rgb_out} !== 13'd0) begin errors++; $display("FAIL lat_n2 got=%h exp=0", {text_hit, rgb_out}); end
    @(negedge clk);
    checks++;
    if ({text_hit, rgb_out} !== {1'b1, FG}) begin errors++; $display("FAIL lat_n3 got=%h exp=%h", {text_hit, rgb_out}, {1'b1, FG}); end
    @(negedge clk);
    checks++;
    if ({text_hit, rgb_out} !== 13'd0) begin errors++; $display("FAIL lat_n4 got=%h exp=0", {text_hit, rgb_out}); end
    probe(10'd193, 10'd65, 1'b1, a, p);
    checks++;
    if (p !== {1'b1, FG}) begin errors++; $display("FAIL scale_193_65 got=%h exp=%h", p, {1'b1, FG}); end
    probe(10'd195, 10'd67, 1'b1, a, p);
    checks++;
    if (p !== {1'b1, FG}) begin errors++; $display("FAIL scale_195_67 got=%h exp=%h", p, {1'b1, FG}); end
    probe(10'd203, 10'd64, 1'b1, a, p);
    checks++;
    if (p !== {1'b1, FG}) begin errors++; $display("FAIL scale_203 got=%h exp=%h", p, {1'b1, FG}); end
    probe(10'd204, 10'd67, 1'b1, a, p);
    checks++;
    if (p !== {1'b1, 12'h000}) begin errors++; $display("FAIL scale_204 got=%h exp=1000", p); end
    probe(10'd192, 10'd68, 1'b1, a, p);
    checks++;
    if (a !== 8'h11) begin errors++; $display("FAIL scale_row1_addr got=%h exp=11", a); end
  endtask

  task test_snapshot();
    logic [7:0] a; logic [12:0] p;
    time_bcd = 24'h000000;
    tick();
    time_bcd = 24'h595959;
    probe(10'd196, 10'd64, 1'b1, a, p);
    checks++;
    if ({a, p} !== {8'h00, 1'b1, FG}) begin errors++; $display("FAIL snap_old got=%h exp=%h", {a, p}, {8'h00, 1'b1, FG}); end
    probe(10'd224, 10'd100, 1'b1, a, p);
    checks++;
    if (a !== 8'h09) begin errors++; $display("FAIL snap_old_row9 got=%h exp=09", a); end
    // frame_tick coincident with a pixel: that pixel still uses the old shadow
    pix_x = 10'd196; pix_y = 10'd64; video_on = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    checks++;
    if (font_addr !== 8'h00) begin errors++; $display("FAIL snap_same_cycle got=%h exp=00", font_addr); end
    @(negedge clk);
    checks++;
    if (font_addr !== 8'h50) begin errors++; $display("FAIL snap_next_cycle got=%h exp=50", font_addr); end
    idle();
    probe(10'd196, 10'd64, 1'b1, a, p);
    checks++;
    if ({a, p} !== {8'h50, 1'b1, 12'h000}) begin errors++; $display("FAIL snap_new got=%h exp=%h", {a, p}, {8'h50, 13'h1000}); end
    probe(10'd224, 10'd64, 1'b1, a, p);
    checks++;
    if (a !== 8'h90) begin errors++; $display("FAIL snap_new_units got=%h exp=90", a); end
  endtask

  task test_blink();
    logic [7:0] a; logic [12:0] p0, p1, p2;
    logic blank;
    time_bcd = 24'h123456; edit_field = 2'd1; edit_en = 1'b1;
    for (int fr = 1; fr <= 6; fr++) begin
      tick();
      blank = (fr == 1 || fr == 2 || fr == 5 || fr == 6);
      probe(10'd192, 10'd64, 1'b1, a, p0);
      probe(10'd320, 10'd64, 1'b1, a, p1);
      probe(10'd448, 10'd64, 1'b1, a, p2);
      checks++;
      if (p1 !== {1'b1, blank ? 12'h000 : FG}) begin
        errors++; $display("FAIL blink_field1 frame=%0d got=%h exp=%h", fr, p1, {1'b1, blank ? 12'h000 : FG});
      end
      checks++;
      if ({p0, p2} !== {1'b1, FG, 1'b1, FG}) begin
        errors++; $display("FAIL blink_other frame=%0d got=%h exp=%h", fr, {p0, p2}, {1'b1, FG, 1'b1, FG});
      end
    end
    edit_field = 2'd3;
    for (int fr = 0; fr < 3; fr++) begin
      tick();
      probe(10'd320, 10'd64, 1'b1, a, p1);
      checks++;
      if (p1 !== {1'b1, FG}) begin errors++; $display("FAIL blink_field3 frame=%0d got=%h exp=%h", fr, p1, {1'b1, FG}); end
    end
    edit_en = 1'b0; edit_field = 2'd0;
    tick();
  endtask

  task test_invalid_bcd();
    logic [7:0] a; logic [12:0] p;
    time_bcd = 24'hA0F000;
    tick();
    probe(10'd192, 10'd64, 1'b1, a, p);
    checks++;
    if (p !== {1'b1, 12'h000}) begin errors++; $display("FAIL bcd_f0_tens got=%h exp=1000", p); end
    probe(10'd224, 10'd64, 1'b1, a, p);
    checks++;
    if (p !== {1'b1, FG}) begin errors++; $display("FAIL bcd_f0_units got=%h exp=%h", p, {1'b1, FG}); end
    probe(10'd320, 10'd64, 1'b1, a, p);
    checks++;
    if (p !== {1'b1, 12'h000}) begin errors++; $display("FAIL bcd_f1_tens got=%h exp=1000", p); end
    probe(10'd191, 10'd64, 1'b1, a, p);
    checks++;
    if (p !== 13'd0) begin errors++; $display("FAIL bound_x191 got=%h exp=0", p); end
    probe(10'd256, 10'd64, 1'b1, a, p);
    checks++;
    if (p !== 13'd0) begin errors++; $display("FAIL bound_x256 got=%h exp=0", p); end
    probe(10'd255, 10'd64, 1'b1, a, p);
    checks++;
    if (p !== {1'b1, FG}) begin errors++; $display("FAIL bound_x255 got=%h exp=%h", p, {1'b1, FG}); end
    probe(10'd224, 10'd128, 1'b1, a, p);
    checks++;
    if (p !== 13'd0) begin errors++; $display("FAIL bound_y128 got=%h exp=0", p); end
    probe(10'd224, 10'd127, 1'b1, a, p);
    checks++;
    if ({a, p} !== {8'h0F, 1'b1, FG}) begin errors++; $display("FAIL bound_y127 got=%h exp=%h", {a, p}, {8'h0F, 1'b1, FG}); end
    probe(10'd224, 10'd64, 1'b0, a, p);
    checks++;
    if (p !== 13'd0) begin errors++; $display("FAIL video_off got=%h exp=0", p); end
  endtask

  task test_reset_midline();
    logic [7:0] a; logic [12:0] p;
    time_bcd = 24'h123456;
    tick();
    for (int i = 0; i < 20; i++) begin
      if (i == 8) begin
        checks++;
        if ({text_hit, rgb_out} !== {1'b1, FG}) begin errors++; $display("FAIL rst_pre got=%h exp=%h", {text_hit, rgb_out}, {1'b1, FG}); end
      end
      if (i >= 9 && i <= 12) begin
        checks++;
        if ({text_hit, rgb_out} !== 13'd0) begin errors++; $display("FAIL rst_out_zero i=%0d got=%h exp=0", i, {text_hit, rgb_out}); end
      end
      if (i >= 9 && i <= 11) begin
        checks++;
        if (font_addr !== 8'h00) begin errors++; $display("FAIL rst_addr i=%0d got=%h exp=00", i, font_addr); end
      end
      if (i == 13) begin
        checks++;
        if ({text_hit, rgb_out} !== {1'b1, FG}) begin errors++; $display("FAIL rst_resume got=%h exp=%h", {text_hit, rgb_out}, {1'b1, FG}); end
      end
      if (i == 15) begin
        checks++;
        if ({text_hit, rgb_out} !== {1'b1, FG}) begin errors++; $display("FAIL rst_shadow_zero got=%h exp=%h", {text_hit, rgb_out}, {1'b1, FG}); end
      end
      pix_x = 10'(192 + i); pix_y = 10'd64; video_on = 1'b1;
      reset = (i == 8 || i == 9);
      @(negedge clk);
    end
    reset = 1'b0; idle();
    tick();
    probe(10'd204, 10'd64, 1'b1, a, p);
    checks++;
    if ({a, p} !== {8'h10, 1'b1, 12'h000}) begin errors++; $display("FAIL rst_after_tick got=%h exp=%h", {a, p}, {8'h10, 13'h1000}); end
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; time_bcd = 24'h0; edit_en = 1'b0; edit_field = 2'd0;
    idle();
    @(negedge clk);
    test_reset();
    test_basic_render();
    test_latency_scaling();
    test_snapshot();
    test_blink();
    test_invalid_bcd();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
